stream_packer: RTL and testbench
================================

# stream_packer

Width-up converter on the valid/ready stream interface. It sits on the read side of the FIFO, consumes `Ratio` narrow beats and emits one packed wide word downstream. Beat 0 goes into the least significant lane. An explicit flush emits a zero-padded partial word together with a lane-keep mask. It sustains one input beat per cycle under no backpressure.

## Interface
Parameters:
- `DataWidth`, 4: width of one input beat.
- `Ratio`, 4: beats per output word, ≥2. Output width is `DataWidth*Ratio`.

Ports:
- `clk_i` input 1: single clock; all state on rising edge.
- `reset_ni` input 1: reset, asynchronous and active-low; one clock.
- `rvalid_i` input 1: input beat valid (driven from FIFO `rvalid_o`).
- `rready_o` output 1: packer accepts beat (drives FIFO `rready_i`).
- `data_i` input DataWidth: input beat.
- `flush_i` input 1: single-cycle request to emit the pending partial word.
- `ovalid_o` output 1: output word valid.
- `oready_i` input 1: downstream accepts word.
- `data_o` output DataWidth*Ratio: packed word; lane k = bits [k*DataWidth +: DataWidth].
- `keep_o` output Ratio: bit k set = lane k holds real data.

## Operation
- State:
  - accumulator `acc` holds lanes 0..Ratio-2;
  - lane counter `cnt` spans 0..Ratio-1, width clog2(Ratio);
  - output register (`data_o`, `keep_o`, `ovalid_o`);
  - `flush_pend` flag;
  - `run` flag, set one cycle after reset release.
- Reset values: `cnt`=0, `acc`=0, `ovalid_o`=0, `data_o`=0, `keep_o`=0, `flush_pend`=0, `run`=0. `rready_o`=0 while `run`=0.
- `out_free` = `!ovalid_o || oready_i`.
- `rready_o` = `run && !flush_pend && (cnt != Ratio-1 || out_free)`. This path is combinational from `oready_i`.
- Beat accept (`rvalid_i && rready_o`):
  - `cnt` < Ratio-1: store `data_i` into lane `cnt`, then `cnt`++.
  - `cnt` == Ratio-1: load the output register with {`data_i`, `acc`}, set `keep_o` to all ones and `ovalid_o`=1, then clear `cnt` to 0 and `acc` to 0.
- Output handshake: `ovalid_o && oready_i` retires the word. `ovalid_o` clears unless a new word loads on the same edge.
- `data_o` and `keep_o` are held stable while `ovalid_o && !oready_i`.
- Flush, sampled at the edge:
  - Let `cnt'` be `cnt` after any beat accepted in the same cycle.
  - If `cnt'`=0, flush is a no-op. This covers an idle packer and a flush coinciding with the completing beat.
  - Otherwise set `flush_pend`.
- While `flush_pend` is set:
  - `rready_o`=0.
  - On the first edge with `out_free`, load the output register with `acc`, unused lanes zero, `keep_o` = (1<<`cnt`)-1.
  - On that same edge clear `cnt`, `acc` and `flush_pend`.
- `flush_i` while `flush_pend` is already set is ignored.
- Reset mid-word or mid-flush: the partial data is discarded and never emitted.

## Timing
- Latency: the completing beat accepted at edge N gives `ovalid_o`=1 and a valid `data_o` in the cycle after N.
- Throughput: with `rvalid_i`=1 and `oready_i`=1, one beat per cycle and one word per Ratio cycles, with no bubbles.
- Backpressure (`ovalid_o`=1, `oready_i`=0):
  - Beats for lanes 0..Ratio-2 of the next word are still accepted.
  - The completing beat stalls with `rready_o`=0 until `oready_i`=1.
  - It is then accepted on that same cycle, and the new word replaces the old one on the edge.
- Flush with the output register free: the `flush_i` edge sets pending. The partial word appears two cycles after the `flush_i` cycle. `rready_o` is low for one cycle.
- After reset release, `rready_o` rises one cycle after the first edge.

## Test plan
DataWidth=4, Ratio=4 for all scenarios.
- **Basic pack:** beats 1,2,3,4 back-to-back with `oready_i`=1 → one word, `data_o`=16'h4321, `keep_o`=4'hF, `ovalid_o` high for exactly 1 cycle, in the cycle after the 4th accept.
- **Streaming:** 12 beats 0..B continuous with `oready_i`=1 → accepted in 12 consecutive cycles. Words in order: 16'h3210, 16'h7654, 16'hBA98. `rready_o` never drops.
- **Backpressure:** `oready_i`=0, send 8 beats 1..8.
  - Word 16'h4321 is held stable.
  - Beats 5,6,7 are accepted; beat 8 stalls with `rready_o`=0.
  - Raise `oready_i` → beat 8 is accepted the same cycle; the next word is 16'h8765.
- **Flush partial:** beats A,B, then pulse `flush_i` → one word 16'h00BA, `keep_o`=4'b0011. `rready_o`=0 while pending. The next 4 beats pack from lane 0.
- **Flush corners:**
  - `flush_i` with `cnt`=0 → no output.
  - `flush_i` in the same cycle as the 4th beat → only the full word 4'hF is emitted; no extra word follows.
  - `flush_i` in the same cycle as the 3rd beat C after A,B → 16'h0CBA, `keep_o`=4'b0111.
- **Async reset mid-word:** after 2 beats, pull `reset_ni` low between edges → outputs are immediately 0 and `rready_o`=0. After release, beats 1..4 yield exactly 16'h4321 with no stale lanes.

Source files
------------

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - width-up stream packer with flush and lane-keep mask
module stream_packer #(
  parameter int DataWidth = 4,
  parameter int Ratio     = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       rvalid_i,
  output logic                       rready_o,
  input  logic [DataWidth-1:0]       data_i,
  input  logic                       flush_i,
  output logic                       ovalid_o,
  input  logic                       oready_i,
  output logic [DataWidth*Ratio-1:0] data_o,
  output logic [Ratio-1:0]           keep_o
);

  localparam int CntW = $clog2(Ratio);
  localparam int AccW = DataWidth * (Ratio - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

  // Accumulator holds every lane except the last; the completing beat goes straight to the output
  logic [AccW-1:0]            acc_q, acc_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [DataWidth*Ratio-1:0] data_q, data_d;
  logic [Ratio-1:0]           keep_q, keep_d;
  logic                       ovalid_q, ovalid_d;
  logic                       flush_pend_q, flush_pend_d;
  logic                       run_q, run_d;

  logic out_free;
  logic rready;
  logic accept;

  // Accept a beat unless a flush is pending or the completing beat has nowhere to go
  always_comb begin
    out_free = !ovalid_q || oready_i;
    rready   = run_q && !flush_pend_q && ((cnt_q != LastCnt) || out_free);
    accept   = rvalid_i && rready;
  end

  // Next-state: lane fill, word completion, output retire and flush sequencing
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    keep_d       = keep_q;
    ovalid_d     = ovalid_q;
    flush_pend_d = flush_pend_q;
    run_d        = 1'b1;

    if (ovalid_q && oready_i) begin
      ovalid_d = 1'b0;
    end

    if (flush_pend_q) begin
      // Drain the partial word once the output register can take it; new flush requests are ignored
      if (out_free) begin
        data_d = {{DataWidth{1'b0}}, acc_q};
        for (int k = 0; k < Ratio; k++) begin
          keep_d[k] = (CntW'(k) < cnt_q);
        end
        ovalid_d     = 1'b1;
        cnt_d        = '0;
        acc_d        = '0;
        flush_pend_d = 1'b0;
      end
    end else begin
      if (accept) begin
        if (cnt_q != LastCnt) begin
          for (int k = 0; k < Ratio - 1; k++) begin
            if (cnt_q == CntW'(k)) begin
              acc_d[k*DataWidth +: DataWidth] = data_i;
            end
          end
          cnt_d = cnt_q + CntW'(1);
        end else begin
          data_d   = {data_i, acc_q};
          keep_d   = '1;
          ovalid_d = 1'b1;
          cnt_d    = '0;
          acc_d    = '0;
        end
      end
      // A flush that lands on an empty accumulator (including right after completion) does nothing
      if (flush_i && (cnt_d != '0)) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any partial word
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      ovalid_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      ovalid_q     <= ovalid_d;
      flush_pend_q <= flush_pend_d;
      run_q        <= run_d;
    end
  end

  assign rready_o = rready;
  assign ovalid_o = ovalid_q;
  assign data_o   = data_q;
  assign keep_o   = keep_q;

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - scoreboard testbench for stream_packer
module tb_stream_packer;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        rvalid_i;
  logic        rready_o;
  logic [3:0]  data_i;
  logic        flush_i;
  logic        ovalid_o;
  logic        oready_i;
  logic [15:0] data_o;
  logic [3:0]  keep_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [15:0] held_d = '0;

  stream_packer #(.DataWidth(4), .Ratio(4)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .rvalid_i(rvalid_i),
    .rready_o(rready_o),
    .data_i  (data_i),
    .flush_i (flush_i),
    .ovalid_o(ovalid_o),
    .oready_i(oready_i),
    .data_o  (data_o),
    .keep_o  (keep_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic [3:0] k);
    exp_q.push_back({k, d});
  endtask

  // Present one beat and hold it until accepted; reports stall cycles
  task automatic send_beat(input logic [3:0] d, input logic fl, output int waited);
    waited   = 0;
    rvalid_i = 1'b1;
    data_i   = d;
    flush_i  = fl;
    @(negedge clk_i);
    while (!rready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!rready_o) check("beat_accept_timeout", 32'(rready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rvalid_i = 1'b0;
    flush_i  = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Monitor: retire words against the scoreboard and check hold stability under backpressure
  always @(negedge clk_i) begin
    if (!reset_ni) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", 32'(ovalid_o), 32'd1);
        check("hold_data", 32'(data_o), 32'(held_d));
      end
      if (ovalid_o && oready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got data %h keep %h expected no word", data_o, keep_o);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("sb_data", 32'(data_o), 32'(e[15:0]));
          check("sb_keep", 32'(keep_o), 32'(e[19:16]));
        end
      end
      held_v = ovalid_o && !oready_i;
      held_d = data_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset_ni = 1'b0;
    rvalid_i = 1'b0;
    data_i   = '0;
    flush_i  = 1'b0;
    oready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_ovalid", 32'(ovalid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_keep", 32'(keep_o), 32'd0);
    check("rst_rready", 32'(rready_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("run_rready_before_edge", 32'(rready_o), 32'd0);
    @(negedge clk_i);
    check("run_rready_after_edge", 32'(rready_o), 32'd1);
    @(posedge clk_i);
    #1;

    // Basic pack
    push_word(16'h4321, 4'hF);
    for (int i = 1; i <= 4; i++) send_beat(4'(i), 1'b0, w);
    @(negedge clk_i);
    check("basic_ovalid", 32'(ovalid_o), 32'd1);
    check("basic_data", 32'(data_o), 32'h4321);
    @(negedge clk_i);
    check("basic_ovalid_one_cycle", 32'(ovalid_o), 32'd0);
    idle(2);

    // Streaming
    push_word(16'h3210, 4'hF);
    push_word(16'h7654, 4'hF);
    push_word(16'hBA98, 4'hF);
    for (int i = 0; i < 12; i++) begin
      send_beat(4'(i), 1'b0, w);
      check("stream_no_stall", 32'(w), 32'd0);
    end
    idle(3);

    // Backpressure
    oready_i = 1'b0;
    push_word(16'h4321, 4'hF);
    push_word(16'h8765, 4'hF);
    for (int i = 1; i <= 4; i++) send_beat(4'(i), 1'b0, w);
    for (int i = 5; i <= 7; i++) begin
      send_beat(4'(i), 1'b0, w);
      check("bp_lane_accept", 32'(w), 32'd0);
    end
    rvalid_i = 1'b1;
    data_i   = 4'h8;
    repeat (3) begin
      @(negedge clk_i);
      check("bp_stall_rready", 32'(rready_o), 32'd0);
      check("bp_held_word", 32'(data_o), 32'h4321);
    end
    @(posedge clk_i);
    #1;
    oready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_rready", 32'(rready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rvalid_i = 1'b0;
    @(negedge clk_i);
    check("bp_new_valid", 32'(ovalid_o), 32'd1);
    check("bp_new_data", 32'(data_o), 32'h8765);
    idle(2);

    // Flush partial
    push_word(16'h00BA, 4'b0011);
    send_beat(4'hA, 1'b0, w);
    send_beat(4'hB, 1'b0, w);
    pulse_flush();
    @(negedge clk_i);
    check("flush_pend_rready", 32'(rready_o), 32'd0);
    check("flush_not_yet_valid", 32'(ovalid_o), 32'd0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("flush_valid", 32'(ovalid_o), 32'd1);
    check("flush_data", 32'(data_o), 32'h00BA);
    check("flush_keep", 32'(keep_o), 32'h3);
    @(posedge clk_i);
    #1;
    push_word(16'h8765, 4'hF);
    for (int i = 5; i <= 8; i++) send_beat(4'(i), 1'b0, w);
    idle(3);

    // Flush with empty accumulator: nothing emitted, no pending state
    pulse_flush();
    @(negedge clk_i);
    check("idle_flush_rready", 32'(rready_o), 32'd1);
    idle(4);

    // Flush on the completing beat: only the full word
    push_word(16'h4321, 4'hF);
    for (int i = 1; i <= 3; i++) send_beat(4'(i), 1'b0, w);
    send_beat(4'h4, 1'b1, w);
    @(negedge clk_i);
    check("flush4_rready", 32'(rready_o), 32'd1);
    idle(5);

    // Flush on the third beat
    push_word(16'h0CBA, 4'b0111);
    send_beat(4'hA, 1'b0, w);
    send_beat(4'hB, 1'b0, w);
    send_beat(4'hC, 1'b1, w);
    idle(5);
    check("sb_drained_mid", 32'(exp_q.size()), 32'd0);

    // Async reset mid-word
    send_beat(4'h1, 1'b0, w);
    send_beat(4'h2, 1'b0, w);
    #2;
    reset_ni = 1'b0;
    #1;
    check("arst_ovalid", 32'(ovalid_o), 32'd0);
    check("arst_data", 32'(data_o), 32'd0);
    check("arst_keep", 32'(keep_o), 32'd0);
    check("arst_rready", 32'(rready_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("arst_rready_held", 32'(rready_o), 32'd0);
    @(posedge clk_i);
    #1;
    push_word(16'h4321, 4'hF);
    for (int i = 1; i <= 4; i++) send_beat(4'(i), 1'b0, w);
    @(negedge clk_i);
    check("arst_word_data", 32'(data_o), 32'h4321);
    check("arst_word_keep", 32'(keep_o), 32'hF);
    idle(5);

    check("sb_drained_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
